// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Frame: SYNC, CNT_HI, CNT_LO, 2*N data bytes, XOR checksum.
package mips_loader_pkg;

    localparam int         DEF_ADDR_W    = 13;
    localparam int         DEF_DATA_W    = 16;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Largest legal word count is a full memory; 17 bits holds 2^16 safely.
    function automatic logic [16:0] max_words(input int addr_w);
        return 17'(1) << addr_w;
    endfunction

    localparam logic [16:0] MAX_WORDS = max_words(DEF_ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_RUN,
        S_ERROR
    } ld_state_e;

endpackage

// File: rtl/mips_loader_word_asm.sv
// Byte-pair to word assembly, running XOR and the registered imem write port.
// The write strobe lands the cycle after the low byte transfers.
module mips_loader_word_asm #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        data_i,
    input  logic              hi_we_i,
    input  logic              lo_we_i,
    input  logic              clr_xor_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [DATA_W-1:0] imem_wdata_o,
    output logic [7:0]        xor_o
);

    logic [7:0]        hi_q;
    logic [7:0]        xor_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q    <= '0;
            xor_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= lo_we_i;
            if (hi_we_i) hi_q <= data_i;
            // Address is captured before the top bumps its word counter.
            if (lo_we_i) begin
                addr_q  <= addr_i;
                wdata_q <= DATA_W'({hi_q, data_i});
            end
            if (clr_xor_i)
                xor_q <= '0;
            else if (hi_we_i || lo_we_i)
                xor_q <= xor_q ^ data_i;
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign xor_o        = xor_q;

endmodule

// File: rtl/mips_prog_loader.sv
// Boot loader: parses a framed byte stream into imem writes, holding the CPU
// in reset until the checksum matches.
module mips_prog_loader
    import mips_loader_pkg::*;
#(
    parameter int         ADDR_W    = DEF_ADDR_W,
    parameter int         DATA_W    = DEF_DATA_W,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [16:0] MAX_N = max_words(ADDR_W);

    ld_state_e       state_q;
    logic [15:0]     cnt_q;
    logic [ADDR_W:0] words_q;
    logic            ready_q, hold_q, done_q, err_q;
    logic [7:0]      xor_w;

    logic        xfer;
    logic [16:0] cnt_full;
    logic        last_word;

    assign xfer      = in_valid && ready_q;
    assign cnt_full  = {1'b0, cnt_q[15:8], in_data};
    assign last_word = (17'(words_q) + 17'd1) == {1'b0, cnt_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            words_q <= '0;
            ready_q <= 1'b1;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (xfer) begin
            case (state_q)
                S_IDLE:
                    if (in_data == SYNC_BYTE) state_q <= S_CNT_HI;
                S_CNT_HI: begin
                    cnt_q[15:8] <= in_data;
                    state_q     <= S_CNT_LO;
                end
                S_CNT_LO: begin
                    cnt_q[7:0] <= in_data;
                    if (cnt_full > MAX_N) begin
                        state_q <= S_ERROR;
                        ready_q <= 1'b0;
                        err_q   <= 1'b1;
                    end else if (cnt_full == '0) begin
                        state_q <= S_CHECK;
                    end else begin
                        state_q <= S_DATA_HI;
                    end
                end
                S_DATA_HI:
                    state_q <= S_DATA_LO;
                S_DATA_LO: begin
                    words_q <= words_q + 1'b1;
                    state_q <= last_word ? S_CHECK : S_DATA_HI;
                end
                S_CHECK: begin
                    ready_q <= 1'b0;
                    if (in_data == xor_w) begin
                        state_q <= S_RUN;
                        hold_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_ERROR;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    mips_loader_word_asm #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_word_asm (
        .clk          (clk),
        .rst          (rst),
        .data_i       (in_data),
        .hi_we_i      (xfer && state_q == S_DATA_HI),
        .lo_we_i      (xfer && state_q == S_DATA_LO),
        .clr_xor_i    (xfer && state_q == S_IDLE && in_data == SYNC_BYTE),
        .addr_i       (words_q[ADDR_W-1:0]),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_wdata_o (imem_wdata),
        .xor_o        (xor_w)
    );

    assign in_ready     = ready_q;
    assign cpu_hold     = hold_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Frame-level bench: builds frames from word lists, predicts writes and
// final status from the frame contents, and compares against captured writes.
module tb_mips_prog_loader;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_hold, load_done, load_err;
    logic [ADDR_W:0]   words_loaded;

    mips_prog_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
        .load_err(load_err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    bit gaps = 1'b0;

    int cap_addr[$], cap_data[$], cap_cyc[$], cap_wl[$];
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            cap_addr.push_back(int'(imem_addr));
            cap_data.push_back(int'(imem_wdata));
            cap_cyc.push_back(cyc);
            cap_wl.push_back(int'(words_loaded));
        end
    end

    logic [7:0]  pre[$];
    logic [15:0] fw[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            if (errors < 20) $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cap_addr.delete(); cap_data.delete(); cap_cyc.delete(); cap_wl.delete();
        pre.delete(); fw.delete();
    endtask

    // Called at a negedge; returns the index of the edge on which the byte transferred.
    task automatic send_byte(input logic [7:0] b, output int k);
        int w;
        if (gaps && $urandom_range(3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        in_data = b; in_valid = 1'b1; w = 0;
        while (in_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (in_ready !== 1'b1) begin
            chk("ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            k = -1;
            return;
        end
        k = cyc + 1;
        @(negedge clk);
    endtask

    // Sends pre, then a frame built from fw; chk_flip != 0 corrupts the checksum.
    task automatic do_frame(input string tag, input logic [7:0] chk_flip);
        logic [7:0] x;
        int k, n;
        int lo_k[$];
        bit ok;
        n = fw.size();
        x = 8'h00;
        foreach (pre[i]) send_byte(pre[i], k);
        send_byte(8'hA5, k);
        send_byte(n[15:8], k);
        send_byte(n[7:0], k);
        for (int i = 0; i < n; i++) begin
            send_byte(fw[i][15:8], k);
            send_byte(fw[i][7:0], k);
            x = x ^ fw[i][15:8] ^ fw[i][7:0];
            lo_k.push_back(k);
        end
        chk({tag, "_done_before_chk"}, 32'(load_done), 32'd0);
        send_byte(x ^ chk_flip, k);
        in_valid = 1'b0;
        ok = (chk_flip == 8'h00);
        chk({tag, "_nwrites"}, 32'(cap_addr.size()), 32'(n));
        for (int i = 0; i < n && i < cap_addr.size(); i++) begin
            chk({tag, "_addr"}, 32'(cap_addr[i]), 32'(i));
            chk({tag, "_data"}, 32'(cap_data[i]), 32'(fw[i]));
            chk({tag, "_wcyc"}, 32'(cap_cyc[i]), 32'(lo_k[i]));
            chk({tag, "_wl_at_we"}, 32'(cap_wl[i]), 32'(i + 1));
        end
        chk({tag, "_done"}, 32'(load_done), 32'(ok));
        chk({tag, "_err"}, 32'(load_err), 32'(!ok));
        chk({tag, "_hold"}, 32'(cpu_hold), 32'(!ok));
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'(n));
    endtask

    initial begin
        int k, n;
        logic [7:0] b, flip;

        do_reset();
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", 32'(imem_wdata), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);

        // Two-word frame, good checksum (0x08) then bad (0x09).
        fw = '{16'h1234, 16'h5678};
        do_frame("two_ok", 8'h00);
        do_reset();
        fw = '{16'h1234, 16'h5678};
        do_frame("two_bad", 8'h01);

        // Leading garbage is discarded.
        do_reset();
        pre = '{8'h00, 8'hFF, 8'h3C};
        fw = '{16'hABCD};
        do_frame("garbage", 8'h00);

        // Empty program.
        do_reset();
        do_frame("empty", 8'h00);

        // Count 8193 is rejected right after the count bytes.
        do_reset();
        send_byte(8'hA5, k); send_byte(8'h20, k); send_byte(8'h01, k);
        in_valid = 1'b0;
        chk("ovf_err", 32'(load_err), 32'd1);
        chk("ovf_ready", 32'(in_ready), 32'd0);
        chk("ovf_hold", 32'(cpu_hold), 32'd1);
        repeat (3) @(negedge clk);
        chk("ovf_nwrites", 32'(cap_addr.size()), 32'd0);

        // Reset after 3 of 4 data bytes: only the first word lands.
        do_reset();
        send_byte(8'hA5, k); send_byte(8'h00, k); send_byte(8'h02, k);
        send_byte(8'h12, k); send_byte(8'h34, k); send_byte(8'h56, k);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("midrst_nwrites", 32'(cap_addr.size()), 32'd1);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_words", 32'(words_loaded), 32'd0);
        cap_addr.delete(); cap_data.delete(); cap_cyc.delete(); cap_wl.delete();
        fw = '{16'hABCD};
        do_frame("after_rst", 8'h00);

        // Randomized frames with stalls, garbage prefixes and checksum faults.
        gaps = 1'b1;
        for (int f = 0; f < 10; f++) begin
            do_reset();
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                pre.push_back(b);
            end
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) fw.push_back(16'($urandom));
            flip = ($urandom_range(2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            do_frame("rand", flip);
        end

        // Full memory: word 8192 lands at address 8191.
        gaps = 1'b0;
        do_reset();
        for (int i = 0; i < 8192; i++) fw.push_back(16'($urandom));
        do_frame("full", 8'h00);
        if (cap_addr.size() == 8192)
            chk("full_last_addr", 32'(cap_addr[8191]), 32'd8191);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
